// File: rtl/atm_transaction_pkg.sv
// Shared types and constants for the ATM session/transaction controller.
package atm_transaction_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AUTH   = 3'd1,
        CHK    = 3'd2,
        READY  = 3'd3,
        EXEC   = 3'd4,
        DONE   = 3'd5,
        LOCKED = 3'd6
    } atm_state_t;

    typedef enum logic [1:0] {
        OP_INQ = 2'b00,
        OP_WD  = 2'b01,
        OP_DEP = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_INSUF = 3'd1;
    localparam logic [2:0] ERR_OVF   = 3'd2;
    localparam logic [2:0] ERR_ILL   = 3'd3;
    localparam logic [2:0] ERR_LIMIT = 3'd4;

    // An authenticated session is open in these states.
    function automatic logic is_session_state(input atm_state_t s);
        return (s == READY) || (s == EXEC) || (s == DONE);
    endfunction

endpackage

// File: rtl/atm_transaction_if.sv
// Bus between cardhandling / user panel and the transaction controller.
interface atm_transaction_if #(
    parameter int unsigned BW = 20
) ();

    logic          card_in;
    logic          pin_entered;
    logic          wrong_psw;
    logic [BW-1:0] balance;
    logic          op_valid;
    logic [1:0]    op_sel;
    logic [BW-1:0] amount;
    logic [BW-1:0] updated_balance;
    logic          op_done;
    logic          authorized;
    logic          card_retained;
    logic [2:0]    err_code;

    modport master (
        output card_in, pin_entered, wrong_psw, balance, op_valid, op_sel, amount,
        input  updated_balance, op_done, authorized, card_retained, err_code
    );

    modport slave (
        input  card_in, pin_entered, wrong_psw, balance, op_valid, op_sel, amount,
        output updated_balance, op_done, authorized, card_retained, err_code
    );

endinterface

// File: rtl/atm_transaction_pin_attempt_counter.sv
// Saturating wrong-PIN counter; final_try_o flags that one more miss reaches max_tries.
module atm_transaction_pin_attempt_counter #(
    parameter int unsigned MAX_TRIES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic final_try_o
);

    localparam logic [2:0] MAX_C = 3'(MAX_TRIES);

    logic [2:0] count_q;

    // Attempt count register: clear has priority over increment, saturates at max.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 3'd0;
        end else if (clr_i) begin
            count_q <= 3'd0;
        end else if (inc_i && (count_q != MAX_C)) begin
            count_q <= count_q + 3'd1;
        end else begin
            count_q <= count_q;
        end
    end

    assign final_try_o = (count_q == (MAX_C - 3'd1));

endmodule

// File: rtl/atm_transaction.sv
// Session/transaction controller downstream of cardhandling.
// Optional per-session withdrawal cap enabled by defining DAILY_LIMIT_EN.
module atm_transaction
    import atm_transaction_pkg::*;
#(
    parameter int unsigned               balance_width = 20,
    parameter int unsigned               max_tries     = 3,
    parameter logic [balance_width-1:0]  wd_limit      = 20'd5000
) (
    input  logic               clk,
    input  logic               rst,
    atm_transaction_if.slave   bus
);

    localparam int unsigned BW = balance_width;

    atm_state_t    state_q, state_d;
    op_t           op_q, op_d;
    logic [BW-1:0] amount_q, amount_d;
    logic [BW-1:0] result_q, result_d;
    logic [2:0]    err_q, err_d;
    logic          op_done_q;
    logic          authorized_q;
    logic          retained_q;

    logic          cnt_clr_s;
    logic          cnt_inc_s;
    logic          final_try_s;
    logic [BW:0]   dep_sum_s;

`ifdef DAILY_LIMIT_EN
    logic [BW:0]   wd_sum_q, wd_sum_d;
    logic [BW+1:0] wd_total_s;

    assign wd_total_s = {1'b0, wd_sum_q} + {2'b00, amount_q};
`else
    logic          unused_wd_limit_s;

    assign unused_wd_limit_s = ^wd_limit;
`endif

    assign dep_sum_s = {1'b0, bus.balance} + {1'b0, amount_q};

    atm_transaction_pin_attempt_counter #(
        .MAX_TRIES (max_tries)
    ) u_pin_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cnt_clr_s),
        .inc_i       (cnt_inc_s),
        .final_try_o (final_try_s)
    );

    // Next-state and datapath; card removal aborts any session state.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        amount_d  = amount_q;
        result_d  = result_q;
        err_d     = err_q;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
`ifdef DAILY_LIMIT_EN
        wd_sum_d  = wd_sum_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_clr_s = 1'b1;
`ifdef DAILY_LIMIT_EN
                wd_sum_d  = '0;
`endif
                if (bus.card_in) begin
                    state_d = AUTH;
                    err_d   = ERR_NONE;
                end else begin
                    state_d = IDLE;
                end
            end
            AUTH: begin
                if (!bus.card_in) begin
                    state_d = IDLE;
                end else if (bus.pin_entered) begin
                    state_d = CHK;
                end else begin
                    state_d = AUTH;
                end
            end
            CHK: begin
                if (!bus.card_in) begin
                    state_d = IDLE;
                end else if (!bus.wrong_psw) begin
                    state_d = READY;
                end else begin
                    cnt_inc_s = 1'b1;
                    state_d   = final_try_s ? LOCKED : AUTH;
                end
            end
            READY: begin
                if (!bus.card_in) begin
                    state_d = IDLE;
                end else if (bus.op_valid) begin
                    op_d     = op_t'(bus.op_sel);
                    amount_d = bus.amount;
                    err_d    = ERR_NONE;
                    state_d  = EXEC;
                end else begin
                    state_d = READY;
                end
            end
            EXEC: begin
                if (!bus.card_in) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    result_d = bus.balance;
                    case (op_q)
                        OP_INQ: begin
                            err_d = ERR_NONE;
                        end
                        OP_WD: begin
                            // Insufficient funds takes priority over the session cap.
                            if (amount_q > bus.balance) begin
                                err_d = ERR_INSUF;
`ifdef DAILY_LIMIT_EN
                            end else if (wd_total_s > {2'b00, wd_limit}) begin
                                err_d = ERR_LIMIT;
`endif
                            end else begin
                                result_d = bus.balance - amount_q;
`ifdef DAILY_LIMIT_EN
                                wd_sum_d = wd_total_s[BW:0];
`endif
                            end
                        end
                        OP_DEP: begin
                            if (dep_sum_s[BW]) begin
                                err_d = ERR_OVF;
                            end else begin
                                result_d = dep_sum_s[BW-1:0];
                            end
                        end
                        OP_ILL: begin
                            err_d = ERR_ILL;
                        end
                        default: begin
                            err_d = ERR_ILL;
                        end
                    endcase
                end
            end
            DONE: begin
                state_d = bus.card_in ? READY : IDLE;
            end
            LOCKED: begin
                state_d = bus.card_in ? LOCKED : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs track the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            op_q         <= OP_INQ;
            amount_q     <= '0;
            result_q     <= '0;
            err_q        <= ERR_NONE;
            op_done_q    <= 1'b0;
            authorized_q <= 1'b0;
            retained_q   <= 1'b0;
`ifdef DAILY_LIMIT_EN
            wd_sum_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            amount_q     <= amount_d;
            result_q     <= result_d;
            err_q        <= err_d;
            op_done_q    <= (state_d == DONE);
            authorized_q <= is_session_state(state_d);
            retained_q   <= (state_d == LOCKED);
`ifdef DAILY_LIMIT_EN
            wd_sum_q     <= wd_sum_d;
`endif
        end
    end

    // Outside DONE the write-back simply returns the balance it was given.
    assign bus.updated_balance = (state_q == DONE) ? result_q : bus.balance;
    assign bus.op_done         = op_done_q;
    assign bus.authorized      = authorized_q;
    assign bus.card_retained   = retained_q;
    assign bus.err_code        = err_q;

endmodule

// File: tb/tb_atm_transaction.sv
// Directed self-checking bench for atm_transaction (bw=20, max_tries=3).
module tb_atm_transaction;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    atm_transaction_if #(.BW(20)) bus ();

    atm_transaction #(
        .balance_width (20),
        .max_tries     (3),
        .wd_limit      (20'd5000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pin_try(input logic wrong);
        bus.pin_entered = 1'b1;
        tick();
        bus.pin_entered = 1'b0;
        bus.wrong_psw   = wrong;
        tick();
        bus.wrong_psw   = 1'b0;
    endtask

    // Issue an op from READY and stop in the DONE cycle.
    task automatic run_op(input logic [1:0] sel, input logic [19:0] amt);
        bus.op_valid = 1'b1;
        bus.op_sel   = sel;
        bus.amount   = amt;
        tick();
        bus.op_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst             = 1'b0;
        bus.card_in     = 1'b0;
        bus.pin_entered = 1'b0;
        bus.wrong_psw   = 1'b0;
        bus.balance     = 20'd1000;
        bus.op_valid    = 1'b0;
        bus.op_sel      = 2'b00;
        bus.amount      = 20'd0;
        tick();
        tick();
        chk("rst_op_done", {31'd0, bus.op_done}, 32'd0);
        chk("rst_authorized", {31'd0, bus.authorized}, 32'd0);
        chk("rst_retained", {31'd0, bus.card_retained}, 32'd0);
        chk("rst_err", {29'd0, bus.err_code}, 32'd0);
        chk("rst_updated_balance", {12'd0, bus.updated_balance}, 32'd1000);
        rst = 1'b1;

        bus.card_in = 1'b1;
        tick();
        chk("auth_not_authorized", {31'd0, bus.authorized}, 32'd0);
        pin_try(1'b0);
        chk("ready_authorized", {31'd0, bus.authorized}, 32'd1);
        bus.pin_entered = 1'b1;
        tick();
        bus.pin_entered = 1'b0;
        chk("pin_ignored_in_ready", {31'd0, bus.authorized}, 32'd1);

        bus.op_valid = 1'b1;
        bus.op_sel   = 2'b01;
        bus.amount   = 20'd300;
        tick();
        bus.op_valid = 1'b0;
        chk("wd300_no_done_yet", {31'd0, bus.op_done}, 32'd0);
        tick();
        chk("wd300_done", {31'd0, bus.op_done}, 32'd1);
        chk("wd300_result", {12'd0, bus.updated_balance}, 32'd700);
        chk("wd300_err", {29'd0, bus.err_code}, 32'd0);
        tick();
        chk("done_one_cycle", {31'd0, bus.op_done}, 32'd0);
        chk("ready_passthrough", {12'd0, bus.updated_balance}, 32'd1000);

        run_op(2'b01, 20'd1000);
        chk("wd_all_result", {12'd0, bus.updated_balance}, 32'd0);
        chk("wd_all_err", {29'd0, bus.err_code}, 32'd0);
        tick();
        run_op(2'b01, 20'd1001);
        chk("wd_insuf_done", {31'd0, bus.op_done}, 32'd1);
        chk("wd_insuf_err", {29'd0, bus.err_code}, 32'd1);
        chk("wd_insuf_result", {12'd0, bus.updated_balance}, 32'd1000);
        tick();

        bus.balance = 20'hFFFFE;
        run_op(2'b10, 20'd2);
        chk("dep_ovf_err", {29'd0, bus.err_code}, 32'd2);
        chk("dep_ovf_result", {12'd0, bus.updated_balance}, 32'h000FFFFE);
        tick();
        run_op(2'b10, 20'd1);
        chk("dep_max_err", {29'd0, bus.err_code}, 32'd0);
        chk("dep_max_result", {12'd0, bus.updated_balance}, 32'h000FFFFF);
        tick();
        run_op(2'b11, 20'd5);
        chk("illegal_err", {29'd0, bus.err_code}, 32'd3);
        chk("illegal_result", {12'd0, bus.updated_balance}, 32'h000FFFFE);
        tick();
        chk("err_held_in_ready", {29'd0, bus.err_code}, 32'd3);
        run_op(2'b00, 20'd77);
        chk("inquiry_err", {29'd0, bus.err_code}, 32'd0);
        chk("inquiry_result", {12'd0, bus.updated_balance}, 32'h000FFFFE);
        tick();

        bus.op_valid = 1'b1;
        bus.op_sel   = 2'b01;
        bus.amount   = 20'd10;
        bus.card_in  = 1'b0;
        tick();
        bus.op_valid = 1'b0;
        chk("abort_deauth", {31'd0, bus.authorized}, 32'd0);
        tick();
        chk("abort_no_done", {31'd0, bus.op_done}, 32'd0);

        bus.balance = 20'd1000;
        bus.card_in = 1'b1;
        tick();
        pin_try(1'b0);
        bus.op_valid = 1'b1;
        bus.op_sel   = 2'b01;
        bus.amount   = 20'd300;
        tick();
        bus.op_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_exec_op_done", {31'd0, bus.op_done}, 32'd0);
        chk("rst_exec_authorized", {31'd0, bus.authorized}, 32'd0);
        chk("rst_exec_passthrough", {12'd0, bus.updated_balance}, 32'd1000);
        rst = 1'b1;

        tick();
        pin_try(1'b1);
        chk("wrong1_not_locked", {31'd0, bus.card_retained}, 32'd0);
        pin_try(1'b1);
        pin_try(1'b1);
        chk("wrong3_locked", {31'd0, bus.card_retained}, 32'd1);
        chk("locked_not_authorized", {31'd0, bus.authorized}, 32'd0);
        run_op(2'b01, 20'd100);
        chk("locked_op_ignored", {31'd0, bus.op_done}, 32'd0);
        chk("locked_stays", {31'd0, bus.card_retained}, 32'd1);
        bus.card_in = 1'b0;
        tick();
        chk("unlock_on_removal", {31'd0, bus.card_retained}, 32'd0);

        bus.card_in = 1'b1;
        tick();
        pin_try(1'b1);
        bus.card_in = 1'b0;
        tick();
        bus.card_in = 1'b1;
        tick();
        pin_try(1'b1);
        pin_try(1'b1);
        chk("attempts_cleared", {31'd0, bus.card_retained}, 32'd0);
        pin_try(1'b0);
        chk("login_after_misses", {31'd0, bus.authorized}, 32'd1);

        bus.balance = 20'd9000;
        run_op(2'b01, 20'd3000);
        chk("limit_first_err", {29'd0, bus.err_code}, 32'd0);
        chk("limit_first_result", {12'd0, bus.updated_balance}, 32'd6000);
        tick();
        run_op(2'b01, 20'd2500);
`ifdef DAILY_LIMIT_EN
        chk("limit_second_err", {29'd0, bus.err_code}, 32'd4);
        chk("limit_second_result", {12'd0, bus.updated_balance}, 32'd9000);
`else
        chk("nolimit_second_err", {29'd0, bus.err_code}, 32'd0);
        chk("nolimit_second_result", {12'd0, bus.updated_balance}, 32'd6500);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
